// File: rtl/accum_feed_ctrl.sv
// Feed/control stage for the accumulator register stage.
// Forms accum_fb +/- operand per batch and captures the final sum.
module accum_feed_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ACCUM_INIT = '0,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_terms,
  input  logic                  clear,
  input  logic                  op_valid,
  input  logic [DATA_WIDTH-1:0] op_data,
  input  logic                  op_sub,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] accum_fb,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  stg_en,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [CNT_WIDTH-1:0]  remaining, remaining_nx;
  logic                  ovf_acc, ovf_acc_nx;
  logic                  hs;
  logic                  step_ovf;
  logic [DATA_WIDTH-1:0] sum_raw;
  logic                  sa, sb, ss;

  assign op_ready = (state == ACCUM) & ~clear;
  assign hs       = op_valid & op_ready;
  assign stg_en   = (state == ACCUM) | (state == DONE);
  assign busy     = (state != IDLE);

  assign sum_raw = op_sub ? (accum_fb - op_data)
                          : (accum_fb + op_data);
  assign sum_out = hs ? sum_raw : accum_fb;

  // Subtract overflows when signs differ and the result leaves a's sign.
  assign sa = accum_fb[DATA_WIDTH-1];
  assign sb = op_data[DATA_WIDTH-1];
  assign ss = sum_raw[DATA_WIDTH-1];
  assign step_ovf = op_sub ? ((sa != sb) & (ss != sa))
                           : ((sa == sb) & (ss != sa));

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    ovf_acc_nx   = ovf_acc;
    if (clear) begin
      state_nx     = IDLE;
      remaining_nx = '0;
      ovf_acc_nx   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ovf_acc_nx = 1'b0;
            if (num_terms != '0) begin
              state_nx     = ACCUM;
              remaining_nx = num_terms;
            end else begin
              state_nx = DONE;
            end
          end
        end
        ACCUM: begin
          if (hs) begin
            remaining_nx = remaining - CNT_WIDTH'(1);
            ovf_acc_nx   = ovf_acc | step_ovf;
            if (remaining == CNT_WIDTH'(1))
              state_nx = DONE;
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      ovf_acc   <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      ovf_acc   <= ovf_acc_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      result     <= ACCUM_INIT;
      result_ovf <= 1'b0;
    end else begin
      done <= (state == DONE) & ~clear;
      if ((state == DONE) && !clear) begin
        result     <= accum_fb;
        result_ovf <= ovf_acc;
      end
    end
  end

endmodule
